weight_load_ctrl: RTL and testbench
===================================

// Module: weight_load_ctrl
// PURPOSE
//  Upstream feeder for the weight/bias write ports of the memory pool (load side).
//  - Takes a valid/ready beat stream of weight/bias words from the load DMA.
//  - Scatters each beat round-robin across the CHL_PARA weight banks, then writes the bias words.
//  - Generates registered write-enable, bank, address and data for the weight and bias groups.
//  - Signals done when a programmed transfer completes.
// PARAMETERS
//  CHL_PARA         8   units per bank; number of weight banks
//  BANK_UNIT_WIDTH  8   bits per unit
//  WEIT_ADDR_WIDTH  12  weight bank address width
//  BIAS_ADDR_WIDTH  8   bias bank address width
// PORTS
//  clk                  in   1                          single clock, all logic rising edge
//  rst_n                in   1                          reset, asynchronous, active-low
//  start_i              in   1                          1-cycle pulse: latch cfg, begin transfer
//  weit_base_i          in   WEIT_ADDR_WIDTH            first weight address
//  weit_len_i           in   WEIT_ADDR_WIDTH+1          weight rows to write (each row = CHL_PARA beats)
//  bias_base_i          in   BIAS_ADDR_WIDTH            first bias address
//  bias_len_i           in   BIAS_ADDR_WIDTH+1          bias rows to write (1 beat each)
//  busy_o               out  1                          transfer in progress
//  done_o               out  1                          1-cycle completion pulse
//  s_data_i             in   CHL_PARA*BANK_UNIT_WIDTH   stream beat
//  s_valid_i            in   1                          beat valid
//  s_ready_o            out  1                          beat accepted when valid & ready
//  weight_write_en_o    out  1                          weight write strobe
//  weight_write_bank_o  out  CHL_PARA                   one-hot bank select
//  weight_write_addr_o  out  WEIT_ADDR_WIDTH            weight address
//  weight_write_data_o  out  CHL_PARA*CHL_PARA*BANK_UNIT_WIDTH  beat replicated into every bank slot
//  bias_write_en_o      out  1                          bias write strobe
//  bias_write_bank_o    out  1                          always 1 when writing
//  bias_write_addr_o    out  BIAS_ADDR_WIDTH            bias address
//  bias_write_data_o    out  CHL_PARA*BANK_UNIT_WIDTH   bias word
// BEHAVIOUR
//  Reset: state IDLE.
//  - Outputs: busy_o, done_o, s_ready_o, both write enables, all bank/addr/data outputs = 0.
//  - Async assert; release is synchronous to clk at the top level.
//  FSM: IDLE -> WEIT -> BIAS -> DONE -> IDLE.
//  - IDLE + start_i: latch cfg.
//    - Go to WEIT if weit_len!=0.
//    - Else go to BIAS if bias_len!=0.
//    - Else go to DONE.
//  - WEIT: s_ready_o=1.
//    - Each accepted beat writes bank b (b counts 0..CHL_PARA-1) at address weit_base+row.
//    - After bank CHL_PARA-1, increment row and reset b to 0.
//    - After the last beat of row weit_len-1, go to BIAS (or DONE if bias_len==0).
//  - BIAS: s_ready_o=1.
//    - Each accepted beat writes bias address bias_base+row.
//    - After beat bias_len-1, go to DONE.
//  - DONE: done_o=1 for exactly one cycle, then IDLE.
//  Timing and ordering:
//  - Write outputs are registered: a beat accepted at edge N gives a 1-cycle strobe in cycle N+1.
//    Full throughput: 1 beat per cycle, no bubbles.
//  - s_ready_o drops in the same cycle the state leaves WEIT/BIAS; no beat is accepted in DONE.
//  - done_o asserts the cycle after the final write strobe.
//  - busy_o = (state != IDLE), including DONE.
//  - When s_valid_i is low, no strobe, and bank/row counters hold.
//  Boundaries:
//  - Address arithmetic is modulo 2^ADDR_WIDTH; base+row wraps silently past the top.
//  - Max lengths: weit_len = 2^WEIT_ADDR_WIDTH, bias_len = 2^BIAS_ADDR_WIDTH.
//  - start_i while busy_o=1 is ignored; latched cfg is unchanged.
//  - start_i in the same cycle as done_o is ignored; the next start is accepted from IDLE.
//  - Reset mid-transfer: abort immediately to IDLE, all outputs to reset values, no done_o.
//  - Bank/addr/data outputs hold their last values while the enables are low.
// CONFIGURATION
//  Macro WEIGHT_LOAD_CKSUM_EN.
//  - Defined: adds output cksum_o[31:0], the running sum mod 2^32 of every accepted beat's
//    unsigned units (weights and bias).
//    - Cleared to 0 on an accepted start_i.
//    - Updated in the same cycle as the matching write strobe.
//    - Stable from done_o until the next start.
//    - Reset value 0.
//  - Undefined: port and logic are absent; all other behaviour is identical.
// TESTING
//  1. Reset check: hold rst_n=0 mid-run -> all outputs 0, state IDLE.
//     Release, start weit_len=1, bias_len=0 -> 8 strobes then done_o.
//  2. CHL_PARA=8, weit_base=0x010, weit_len=2, bias_len=0; 16 back-to-back beats ->
//     - bank 0x01..0x80 at addr 0x010, then again at 0x011;
//     - 16 consecutive strobes, then done_o 1 cycle later.
//  3. weit_len=0, bias_base=0xFE, bias_len=3; beats A,B,C ->
//     - bias writes at 0xFE, 0xFF, 0x00 (wrap);
//     - no weight strobe; done_o after C.
//  4. weit_len=1, bias_len=1; s_valid_i toggles 1/0 each cycle ->
//     - 9 strobes, each 1 cycle after its acceptance;
//     - counters hold during gaps; weight-to-bias handoff is correct.
//  5. start_i pulsed again while busy with different cfg -> ignored; original addresses completed.
//     start_i with both lengths 0 -> done_o 2 cycles later, no strobes.
//  6. (WEIGHT_LOAD_CKSUM_EN) 8 beats of all-0x01 units, 8 units each -> cksum_o = 64 at done_o.
//     Next start clears it to 0.

Source files
------------

// File: rtl/weight_load_ctrl_if.sv
// Valid/ready beat stream from the load DMA into weight_load_ctrl.
// master drives data/valid, slave returns ready.
interface weight_load_ctrl_if #(
    parameter int DATA_W = 64
) ();
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: scatters a beat stream over the weight banks, then bias.
// Optional WEIGHT_LOAD_CKSUM_EN adds cksum_o, a running unit sum of beats.
module weight_load_ctrl #(
    parameter int CHL_PARA        = 8,
    parameter int BANK_UNIT_WIDTH = 8,
    parameter int WEIT_ADDR_WIDTH = 12,
    parameter int BIAS_ADDR_WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic [WEIT_ADDR_WIDTH-1:0] weit_base_i,
    input  logic [WEIT_ADDR_WIDTH:0]   weit_len_i,
    input  logic [BIAS_ADDR_WIDTH-1:0] bias_base_i,
    input  logic [BIAS_ADDR_WIDTH:0]   bias_len_i,
    output logic busy_o,
    output logic done_o,
    weight_load_ctrl_if.slave          s_if,
    output logic weight_write_en_o,
    output logic [CHL_PARA-1:0] weight_write_bank_o,
    output logic [WEIT_ADDR_WIDTH-1:0] weight_write_addr_o,
    output logic [CHL_PARA*CHL_PARA*BANK_UNIT_WIDTH-1:0]
                 weight_write_data_o,
    output logic bias_write_en_o,
    output logic bias_write_bank_o,
    output logic [BIAS_ADDR_WIDTH-1:0] bias_write_addr_o,
    output logic [CHL_PARA*BANK_UNIT_WIDTH-1:0] bias_write_data_o
`ifdef WEIGHT_LOAD_CKSUM_EN
    ,
    output logic [31:0] cksum_o
`endif
);
    localparam int WA = WEIT_ADDR_WIDTH;
    localparam int BA = BIAS_ADDR_WIDTH;
    localparam int BEAT_W = CHL_PARA * BANK_UNIT_WIDTH;
    localparam int BANK_W = (CHL_PARA > 1) ? $clog2(CHL_PARA) : 1;

    localparam logic [WA:0] W_ONE = 1;
    localparam logic [BA:0] B_ONE = 1;
    localparam logic [BANK_W-1:0] BANK_INC = 1;
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(CHL_PARA - 1);
    localparam logic [CHL_PARA-1:0] BANK_OH0 = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WEIT,
        S_BIAS,
        S_DONE
    } state_t;

    state_t state_q;

    logic [WA-1:0] wbase_q;
    logic [WA:0]   wlen_q;
    logic [BA-1:0] bbase_q;
    logic [BA:0]   blen_q;

    logic [BANK_W-1:0] bank_q;
    logic [WA:0]       wrow_q;
    logic [BA:0]       brow_q;

    logic busy_q;
    logic done_q;
    logic ready_q;

    logic                       wen_q;
    logic [CHL_PARA-1:0]        wbank_q;
    logic [WA-1:0]              waddr_q;
    logic [CHL_PARA*BEAT_W-1:0] wdata_q;
    logic                       ben_q;
    logic                       bbank_q;
    logic [BA-1:0]              baddr_q;
    logic [BEAT_W-1:0]          bdata_q;

    logic                accept_d;
    logic [WA-1:0]       waddr_d;
    logic [BA-1:0]       baddr_d;
    logic [CHL_PARA-1:0] wbank_d;
    logic                bank_last_d;
    logic                wrow_last_d;
    logic                brow_last_d;

    // Beat acceptance and the address/bank a beat would be written to.
    always_comb begin
        accept_d    = s_if.s_valid && ready_q;
        waddr_d     = wbase_q + wrow_q[WA-1:0];
        baddr_d     = bbase_q + brow_q[BA-1:0];
        wbank_d     = BANK_OH0 << bank_q;
        bank_last_d = (bank_q == BANK_LAST);
        wrow_last_d = (wrow_q == (wlen_q - W_ONE));
        brow_last_d = (brow_q == (blen_q - B_ONE));
    end

    // Transfer FSM with registered handshake, status and write outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wbase_q <= '0;
            wlen_q  <= '0;
            bbase_q <= '0;
            blen_q  <= '0;
            bank_q  <= '0;
            wrow_q  <= '0;
            brow_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            wen_q   <= 1'b0;
            wbank_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            ben_q   <= 1'b0;
            bbank_q <= 1'b0;
            baddr_q <= '0;
            bdata_q <= '0;
        end else begin
            wen_q  <= 1'b0;
            ben_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        wbase_q <= weit_base_i;
                        wlen_q  <= weit_len_i;
                        bbase_q <= bias_base_i;
                        blen_q  <= bias_len_i;
                        bank_q  <= '0;
                        wrow_q  <= '0;
                        brow_q  <= '0;
                        busy_q  <= 1'b1;
                        if (weit_len_i != '0) begin
                            state_q <= S_WEIT;
                            ready_q <= 1'b1;
                        end else if (bias_len_i != '0) begin
                            state_q <= S_BIAS;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_WEIT: begin
                    if (accept_d) begin
                        wen_q   <= 1'b1;
                        wbank_q <= wbank_d;
                        waddr_q <= waddr_d;
                        wdata_q <= {CHL_PARA{s_if.s_data}};
                        if (bank_last_d) begin
                            bank_q <= '0;
                            wrow_q <= wrow_q + W_ONE;
                            if (wrow_last_d) begin
                                if (blen_q != '0) begin
                                    state_q <= S_BIAS;
                                end else begin
                                    state_q <= S_DONE;
                                    ready_q <= 1'b0;
                                end
                            end
                        end else begin
                            bank_q <= bank_q + BANK_INC;
                        end
                    end
                end
                S_BIAS: begin
                    if (accept_d) begin
                        ben_q   <= 1'b1;
                        bbank_q <= 1'b1;
                        baddr_q <= baddr_d;
                        bdata_q <= s_if.s_data;
                        brow_q  <= brow_q + B_ONE;
                        if (brow_last_d) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    // First DONE cycle lets the final strobe retire,
                    // second one carries the done pulse.
                    if (!done_q) begin
                        done_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef WEIGHT_LOAD_CKSUM_EN
    logic [31:0] sum_d;
    logic [31:0] cksum_q;

    // Unsigned sum of the units of the current beat.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < CHL_PARA; i++) begin
            sum_d = sum_d + 32'(s_if.s_data[i*BANK_UNIT_WIDTH +:
                                             BANK_UNIT_WIDTH]);
        end
    end

    // Running checksum: cleared on an accepted start, bumped per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cksum_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            cksum_q <= '0;
        end else if (accept_d) begin
            cksum_q <= cksum_q + sum_d;
        end
    end

    assign cksum_o = cksum_q;
`endif

    assign s_if.s_ready        = ready_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign weight_write_en_o   = wen_q;
    assign weight_write_bank_o = wbank_q;
    assign weight_write_addr_o = waddr_q;
    assign weight_write_data_o = wdata_q;
    assign bias_write_en_o     = ben_q;
    assign bias_write_bank_o   = bbank_q;
    assign bias_write_addr_o   = baddr_q;
    assign bias_write_data_o   = bdata_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl.
// Build with WEIGHT_LOAD_CKSUM_EN to also cover cksum_o.
module tb_weight_load_ctrl;
    localparam int CP = 8;
    localparam int UW = 8;
    localparam int WA = 12;
    localparam int BA = 8;
    localparam int BW = CP * UW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [WA-1:0] wbase = '0;
    logic [WA:0]   wlen = '0;
    logic [BA-1:0] bbase = '0;
    logic [BA:0]   blen = '0;
    logic busy, done;
    logic wen;
    logic [CP-1:0] wbank;
    logic [WA-1:0] waddr;
    logic [CP*BW-1:0] wdata;
    logic ben, bbank;
    logic [BA-1:0] baddr;
    logic [BW-1:0] bdata;
`ifdef WEIGHT_LOAD_CKSUM_EN
    logic [31:0] cksum;
`endif

    always #5 clk = ~clk;

    weight_load_ctrl_if #(.DATA_W(BW)) s_if ();

    weight_load_ctrl #(
        .CHL_PARA(CP),
        .BANK_UNIT_WIDTH(UW),
        .WEIT_ADDR_WIDTH(WA),
        .BIAS_ADDR_WIDTH(BA)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start_i(start),
        .weit_base_i(wbase),
        .weit_len_i(wlen),
        .bias_base_i(bbase),
        .bias_len_i(blen),
        .busy_o(busy),
        .done_o(done),
        .s_if(s_if),
        .weight_write_en_o(wen),
        .weight_write_bank_o(wbank),
        .weight_write_addr_o(waddr),
        .weight_write_data_o(wdata),
        .bias_write_en_o(ben),
        .bias_write_bank_o(bbank),
        .bias_write_addr_o(baddr),
        .bias_write_data_o(bdata)
`ifdef WEIGHT_LOAD_CKSUM_EN
        ,
        .cksum_o(cksum)
`endif
    );

    typedef struct {
        bit            kind;
        logic [CP-1:0] bank;
        logic [WA-1:0] addr;
        logic [BW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sbq[$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int wstb = 0;
    int bstb = 0;
    int last_stb = -100;

    int m_wbase, m_wlen, m_bbase, m_blen, m_idx;
    int m_start_cyc, m_first_cyc;
    logic [31:0] m_sum;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop the scoreboard on every write strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wen) begin
            wstb++;
            last_stb = cyc;
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected addr=%h", waddr);
            end else begin
                e = sbq.pop_front();
                if (e.kind !== 1'b0 || wbank !== e.bank ||
                    waddr !== e.addr ||
                    wdata !== {CP{e.data}} ||
                    cyc !== e.cyc + 1) begin
                    n_fail++;
                    $display("FAIL weight_wr got k0 b=%h a=%h d=%h c=%0d exp k%0d b=%h a=%h d=%h c=%0d",
                             wbank, waddr, wdata[BW-1:0], cyc,
                             e.kind, e.bank, e.addr, e.data, e.cyc + 1);
                end
            end
        end
        if (rst_n && ben) begin
            bstb++;
            last_stb = cyc;
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL bias_unexpected addr=%h", baddr);
            end else begin
                e = sbq.pop_front();
                if (e.kind !== 1'b1 || bbank !== 1'b1 ||
                    {4'h0, baddr} !== e.addr ||
                    bdata !== e.data || cyc !== e.cyc + 1) begin
                    n_fail++;
                    $display("FAIL bias_wr got k1 bk=%b a=%h d=%h c=%0d exp k%0d a=%h d=%h c=%0d",
                             bbank, baddr, bdata, cyc,
                             e.kind, e.addr[BA-1:0], e.data, e.cyc + 1);
                end
            end
        end
    end

    task automatic start_xfer(input int wb, input int wl,
                              input int bb, input int bl);
        @(negedge clk);
        wbase = WA'(wb);
        wlen = (WA+1)'(wl);
        bbase = BA'(bb);
        blen = (BA+1)'(bl);
        start = 1'b1;
        m_wbase = wb;
        m_wlen = wl;
        m_bbase = bb;
        m_blen = bl;
        m_idx = 0;
        m_sum = '0;
        @(negedge clk);
        start = 1'b0;
        m_start_cyc = cyc;
    endtask

    task automatic send_beats(input int n, input bit toggle,
                              input bit ones);
        int sent = 0;
        int guard = 0;
        bit v = 1'b0;
        logic [BW-1:0] d;
        logic [CP-1:0] one = 1;
        exp_t e;
        while (sent < n && guard < 4 * n + 50) begin
            @(negedge clk);
            guard++;
            v = toggle ? !v : 1'b1;
            d = ones ? {CP{8'h01}} : {$urandom, $urandom};
            s_if.s_valid = v;
            s_if.s_data = d;
            #1;
            if (v && s_if.s_ready) begin
                if (m_idx == 0) m_first_cyc = cyc;
                if (m_idx < m_wlen * CP) begin
                    e.kind = 1'b0;
                    e.bank = one << (m_idx % CP);
                    e.addr = WA'(m_wbase + m_idx / CP);
                end else begin
                    e.kind = 1'b1;
                    e.bank = '0;
                    e.addr = {4'h0, BA'(m_bbase + m_idx - m_wlen * CP)};
                end
                e.data = d;
                e.cyc = cyc;
                sbq.push_back(e);
                for (int i = 0; i < CP; i++)
                    m_sum = m_sum + 32'(d[i*UW +: UW]);
                m_idx++;
                sent++;
            end
        end
        @(negedge clk);
        s_if.s_valid = 1'b0;
        n_tests++;
        if (sent != n) begin
            n_fail++;
            $display("FAIL beat_timeout sent=%0d need=%0d", sent, n);
        end
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int at, w0;
        logic [15:0] outs;
        rst_n = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_data = '0;
        repeat (2) @(negedge clk);
        outs = {busy, done, s_if.s_ready, wen, ben, |wbank, |waddr,
                |wdata, bbank, |baddr, |bdata, 5'd0};
        n_tests++;
        if (outs !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outs got=%h exp=0000", outs);
        end
        rst_n = 1'b1;
        start_xfer(12'h123, 2, 8'h10, 1);
        send_beats(3, 1'b0, 1'b0);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid got=%b exp=1", busy);
        end
        rst_n = 1'b0;
        #1;
        outs = {busy, done, s_if.s_ready, wen, ben, |wbank, |waddr,
                |wdata, bbank, |baddr, |bdata, 5'd0};
        n_tests++;
        if (outs !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid got=%h exp=0000", outs);
        end
        sbq.delete();
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done got=%b exp=0", done);
        end
        rst_n = 1'b1;
        w0 = wstb;
        start_xfer(12'h040, 1, 0, 0);
        send_beats(8, 1'b0, 1'b0);
        wait_done(at);
        n_tests++;
        if (wstb - w0 != 8) begin
            n_fail++;
            $display("FAIL rst_strobes got=%0d exp=8", wstb - w0);
        end
        n_tests++;
        if (at != last_stb + 1) begin
            n_fail++;
            $display("FAIL rst_done got=%0d exp=%0d", at, last_stb + 1);
        end
        @(negedge clk);
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL done_pulse got=%b exp=00", {done, busy});
        end
    endtask

    task automatic test_two_rows();
        int at, w0;
        w0 = wstb;
        start_xfer(12'h010, 2, 0, 0);
        send_beats(16, 1'b0, 1'b0);
        wait_done(at);
        n_tests++;
        if (wstb - w0 != 16) begin
            n_fail++;
            $display("FAIL rows_strobes got=%0d exp=16", wstb - w0);
        end
        n_tests++;
        if (last_stb != m_first_cyc + 16) begin
            n_fail++;
            $display("FAIL rows_b2b got=%0d exp=%0d",
                     last_stb, m_first_cyc + 16);
        end
        n_tests++;
        if (at != last_stb + 1 || sbq.size() != 0) begin
            n_fail++;
            $display("FAIL rows_done got=%0d q=%0d exp=%0d q=0",
                     at, sbq.size(), last_stb + 1);
        end
    endtask

    task automatic test_bias_wrap();
        int at, w0, b0;
        w0 = wstb;
        b0 = bstb;
        start_xfer(0, 0, 8'hFE, 3);
        send_beats(3, 1'b0, 1'b0);
        wait_done(at);
        n_tests++;
        if (wstb - w0 != 0 || bstb - b0 != 3) begin
            n_fail++;
            $display("FAIL bias_counts got w=%0d b=%0d exp w=0 b=3",
                     wstb - w0, bstb - b0);
        end
        n_tests++;
        if (at != last_stb + 1 || sbq.size() != 0) begin
            n_fail++;
            $display("FAIL bias_done got=%0d exp=%0d", at, last_stb + 1);
        end
    endtask

    task automatic test_toggle();
        int at, w0, b0;
        w0 = wstb;
        b0 = bstb;
        start_xfer(12'h7FF, 1, 8'h33, 1);
        send_beats(9, 1'b1, 1'b0);
        wait_done(at);
        n_tests++;
        if (wstb - w0 != 8 || bstb - b0 != 1) begin
            n_fail++;
            $display("FAIL tog_counts got w=%0d b=%0d exp w=8 b=1",
                     wstb - w0, bstb - b0);
        end
        n_tests++;
        if (last_stb != m_first_cyc + 17) begin
            n_fail++;
            $display("FAIL tog_last got=%0d exp=%0d",
                     last_stb, m_first_cyc + 17);
        end
        n_tests++;
        if (at != last_stb + 1 || sbq.size() != 0) begin
            n_fail++;
            $display("FAIL tog_done got=%0d exp=%0d", at, last_stb + 1);
        end
    endtask

    task automatic test_start_ignored();
        int at, w0, b0;
        w0 = wstb;
        b0 = bstb;
        start_xfer(12'h100, 1, 0, 0);
        send_beats(2, 1'b0, 1'b0);
        wbase = 12'h200;
        wlen = 13'd3;
        bbase = 8'h44;
        blen = 9'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_beats(6, 1'b0, 1'b0);
        wait_done(at);
        n_tests++;
        if (wstb - w0 != 8 || bstb - b0 != 0) begin
            n_fail++;
            $display("FAIL ign_counts got w=%0d b=%0d exp w=8 b=0",
                     wstb - w0, bstb - b0);
        end
        n_tests++;
        if (at != last_stb + 1 || s_if.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_done got=%0d rdy=%b exp=%0d rdy=0",
                     at, s_if.s_ready, last_stb + 1);
        end
    endtask

    task automatic test_zero_len();
        int at, w0, b0;
        w0 = wstb;
        b0 = bstb;
        start_xfer(12'h300, 0, 8'h20, 0);
        s_if.s_valid = 1'b1;
        wait_done(at);
        n_tests++;
        if (at != m_start_cyc + 1) begin
            n_fail++;
            $display("FAIL zero_done got=%0d exp=%0d",
                     at, m_start_cyc + 1);
        end
        wlen = 13'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if ({busy, s_if.s_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_idle got=%b exp=00", {busy, s_if.s_ready});
        end
        @(negedge clk);
        s_if.s_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || wstb != w0 || bstb != b0) begin
            n_fail++;
            $display("FAIL zero_ign got busy=%b w=%0d b=%0d exp 0 0 0",
                     busy, wstb - w0, bstb - b0);
        end
    endtask

    task automatic test_max_len();
        int at, w0, b0;
        w0 = wstb;
        b0 = bstb;
        start_xfer(12'hFFF, 2, 8'h80, 256);
        send_beats(16 + 256, 1'b0, 1'b0);
        wait_done(at);
        n_tests++;
        if (wstb - w0 != 16 || bstb - b0 != 256) begin
            n_fail++;
            $display("FAIL bmax_counts got w=%0d b=%0d exp w=16 b=256",
                     wstb - w0, bstb - b0);
        end
        n_tests++;
        if (at != last_stb + 1 || sbq.size() != 0) begin
            n_fail++;
            $display("FAIL bmax_done got=%0d exp=%0d", at, last_stb + 1);
        end
        w0 = wstb;
        start_xfer(12'h800, 4096, 0, 0);
        send_beats(4096 * CP, 1'b0, 1'b0);
        wait_done(at);
        n_tests++;
        if (wstb - w0 != 4096 * CP) begin
            n_fail++;
            $display("FAIL wmax_counts got=%0d exp=%0d",
                     wstb - w0, 4096 * CP);
        end
        n_tests++;
        if (at != last_stb + 1 || sbq.size() != 0) begin
            n_fail++;
            $display("FAIL wmax_done got=%0d exp=%0d", at, last_stb + 1);
        end
    endtask

`ifdef WEIGHT_LOAD_CKSUM_EN
    task automatic test_cksum();
        int at;
        start_xfer(12'h020, 1, 0, 0);
        send_beats(8, 1'b0, 1'b1);
        wait_done(at);
        n_tests++;
        if (cksum !== 32'd64 || m_sum !== 32'd64) begin
            n_fail++;
            $display("FAIL cksum_done got=%0d exp=64", cksum);
        end
        start_xfer(12'h021, 0, 0, 0);
        n_tests++;
        if (cksum !== 32'd0) begin
            n_fail++;
            $display("FAIL cksum_clear got=%0d exp=0", cksum);
        end
        wait_done(at);
    endtask
`endif

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data = '0;
        test_reset();
        test_two_rows();
        test_bias_wrap();
        test_toggle();
        test_start_ignored();
        test_zero_len();
        test_max_len();
`ifdef WEIGHT_LOAD_CKSUM_EN
        test_cksum();
`endif
        repeat (2) @(negedge clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover got=%0d exp=0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
